// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the async-FIFO write-port arbiter.
// Used by fifo_wr_arbiter, rr_pick and fifo_wr_arbiter_if.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_BURST_LEN = 4;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter width: one spare bit above the burst index range.
  function automatic int beat_w(input int b);
    return $clog2(b) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO write-side bundle shared by the arbiter and its neighbours.
// The master view belongs to the arbiter, the slave view to the producers and FIFO.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IDX_W = idx_w(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  full;
  logic [NREQ-1:0]       grant;
  logic [IDX_W-1:0]      owner_id;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;

  modport master (
    input  req, req_data, full,
    output grant, owner_id, winc, wdata, busy
  );

  modport slave (
    output req, req_data, full,
    input  grant, owner_id, winc, wdata, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from rr_ptr+1, wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand [NREQ];
  logic [NREQ-1:0]  rot;

  // rot[k] is the request k+1 places past the pointer; wrap without a divider.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum      = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum - (IDX_W+1)'(NREQ))
                                                  : sum[IDX_W-1:0];
      assign rot[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the async FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add saturating word/stall counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = DEFAULT_BURST_LEN
`ifdef FIFO_WR_ARB_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic write_clk,
  input  logic wrst_n,
  fifo_wr_arbiter_if.master bus
`ifdef FIFO_WR_ARB_STATS_EN
  , output logic [NREQ*CNT_W-1:0] word_cnt
  , output logic [CNT_W-1:0]      stall_cnt
`endif
);

  localparam int IDX_W  = idx_w(NREQ);
  localparam int BEAT_W = beat_w(BURST_LEN);

  arb_state_e        state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]  owner_reg, owner_next;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;

  logic              owner_req;
  logic              accept;
  logic              last_beat;
  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign owner_req = bus.req[owner_reg];
  assign accept    = (state_reg == ARB_GRANT) && owner_req && !bus.full;
  assign last_beat = (beat_cnt_reg == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge write_clk) begin
    if (!wrst_n) begin
      state_reg    <= ARB_IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= IDX_W'(NREQ - 1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Every release passes through IDLE, giving the one-cycle bubble between grants.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    unique case (state_reg)
      ARB_IDLE: begin
        if (pick_found) begin
          state_next    = ARB_GRANT;
          grant_next    = pick_onehot;
          owner_next    = pick_idx;
          rr_ptr_next   = pick_idx;
          beat_cnt_next = '0;
        end
      end
      ARB_GRANT: begin
        if (!owner_req || (accept && last_beat)) begin
          state_next    = ARB_IDLE;
          grant_next    = '0;
          owner_next    = '0;
          beat_cnt_next = '0;
        end else if (accept) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign bus.grant    = grant_reg;
  assign bus.owner_id = owner_reg;
  assign bus.busy     = (state_reg == ARB_GRANT);
  assign bus.winc     = accept;
  assign bus.wdata    = (state_reg == ARB_GRANT) ? bus.req_data[owner_reg*DSIZE +: DSIZE]
                                                 : '0;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [CNT_W-1:0] word_cnt_reg [NREQ];
  logic [CNT_W-1:0] stall_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_word_cnt
      always_ff @(posedge write_clk) begin
        if (!wrst_n)
          word_cnt_reg[gi] <= '0;
        else if (accept && (owner_reg == IDX_W'(gi)) && (word_cnt_reg[gi] != '1))
          word_cnt_reg[gi] <= word_cnt_reg[gi] + 1'b1;
      end
      assign word_cnt[gi*CNT_W +: CNT_W] = word_cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge write_clk) begin
    if (!wrst_n)
      stall_cnt_reg <= '0;
    else if ((state_reg == ARB_GRANT) && owner_req && bus.full && (stall_cnt_reg != '1))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requesters produce (i+1)*16 + word index,
// and each cycle checks grant, owner_id, busy, winc and wdata against the plan.
module tb_fifo_wr_arbiter;

  logic clk;
  logic wrst_n;
  int   checks;
  int   passes;
  int   wcnt [4];

  fifo_wr_arbiter_if #(.NREQ(4), .DSIZE(8)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] word_cnt;
  logic [3:0]  stall_cnt;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST_LEN(4), .CNT_W(4)) dut (
    .write_clk (clk),
    .wrst_n    (wrst_n),
    .bus       (bus.master),
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt)
  );
`else
  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST_LEN(4)) dut (
    .write_clk (clk),
    .wrst_n    (wrst_n),
    .bus       (bus.master)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'((i + 1) * 16 + wcnt[i]);
  endtask

  // One clock: drive inputs just after the edge, check outputs 1 time unit later.
  task automatic cyc(input logic rn, input logic [3:0] r, input logic f,
                     input logic [3:0] eg, input logic ew, input string tag);
    int o;
    logic [7:0] ed;
    @(posedge clk);
    #1;
    wrst_n   = rn;
    bus.req  = r;
    bus.full = f;
    drive_data();
    #1;
    o  = oh2idx(eg);
    ed = (eg != 4'h0) ? 8'((o + 1) * 16 + wcnt[o]) : 8'h00;
    chk({tag, "_grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, "_owner"}, 32'(bus.owner_id), 32'(o));
    chk({tag, "_busy"},  32'(bus.busy), 32'(eg != 4'h0));
    chk({tag, "_winc"},  32'(bus.winc), 32'(ew));
    chk({tag, "_wdata"}, 32'(bus.wdata), 32'(ed));
    $display("%0t %s req=%b full=%b grant=%b winc=%b wdata=%h", $time, tag,
             r, f, bus.grant, bus.winc, bus.wdata);
    if (ew) wcnt[o]++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    wrst_n   = 1'b0;
    bus.req  = '0;
    bus.full = 1'b0;
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    drive_data();
    @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_owner", 32'(bus.owner_id), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_winc",  32'(bus.winc), 32'h0);
    chk("rst_wdata", 32'(bus.wdata), 32'h0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_words", 32'(word_cnt), 32'h0);
`endif
    wrst_n = 1'b1;
  endtask

  initial begin
    checks       = 0;
    passes       = 0;
    wrst_n       = 1'b0;
    bus.req      = '0;
    bus.full     = 1'b0;
    bus.req_data = '0;
    for (int i = 0; i < 4; i++) wcnt[i] = 0;

    // Single requester: two bursts of four separated by a bubble.
    do_reset();
    cyc(1, 4'b0001, 0, 4'b0000, 0, "single_c0");
    for (int b = 0; b < 4; b++) cyc(1, 4'b0001, 0, 4'b0001, 1, "single_b1");
    cyc(1, 4'b0001, 0, 4'b0000, 0, "single_bubble");
    for (int b = 0; b < 4; b++) cyc(1, 4'b0001, 0, 4'b0001, 1, "single_b2");
    cyc(1, 4'b0000, 0, 4'b0000, 0, "single_end");

    // Round-robin with all requesting: owners 0,1,2,3,0.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cyc(1, 4'b1111, 0, 4'b0000, 0, "rr_bubble");
      for (int b = 0; b < 4; b++) cyc(1, 4'b1111, 0, 4'(1 << (g % 4)), 1, "rr_beat");
    end
    cyc(1, 4'b0000, 0, 4'b0000, 0, "rr_end");

    // Backpressure: full for five cycles at beat 2 of owner 2.
    do_reset();
    cyc(1, 4'b0100, 0, 4'b0000, 0, "bp_c0");
    cyc(1, 4'b0100, 0, 4'b0100, 1, "bp_beat0");
    cyc(1, 4'b0100, 0, 4'b0100, 1, "bp_beat1");
    for (int s = 0; s < 5; s++) cyc(1, 4'b0100, 1, 4'b0100, 0, "bp_stall");
    cyc(1, 4'b0100, 0, 4'b0100, 1, "bp_beat2");
    cyc(1, 4'b0100, 0, 4'b0100, 1, "bp_beat3");
    cyc(1, 4'b0000, 0, 4'b0000, 0, "bp_release");
`ifdef FIFO_WR_ARB_STATS_EN
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("bp_word_cnt2", 32'(word_cnt[11:8]), 32'd4);
`endif

    // Early drop (with full asserted the same cycle), then 3 wins over 1.
    do_reset();
    cyc(1, 4'b0010, 0, 4'b0000, 0, "drop_c0");
    cyc(1, 4'b0010, 0, 4'b0010, 1, "drop_beat0");
    cyc(1, 4'b0010, 0, 4'b0010, 1, "drop_beat1");
    cyc(1, 4'b0000, 1, 4'b0010, 0, "drop_release");
    cyc(1, 4'b1010, 0, 4'b0000, 0, "drop_bubble");
    cyc(1, 4'b1010, 0, 4'b1000, 1, "drop_next3");
    cyc(1, 4'b0000, 0, 4'b1000, 0, "drop_rel3");
    cyc(1, 4'b0000, 0, 4'b0000, 0, "drop_idle");

    // Reset during owner 3's second beat; fresh full burst afterwards.
    do_reset();
    cyc(1, 4'b1000, 0, 4'b0000, 0, "mrst_c0");
    cyc(1, 4'b1000, 0, 4'b1000, 1, "mrst_beat0");
    cyc(0, 4'b1000, 0, 4'b1000, 1, "mrst_beat1");
    cyc(1, 4'b1000, 0, 4'b0000, 0, "mrst_after");
    for (int b = 0; b < 4; b++) cyc(1, 4'b1000, 0, 4'b1000, 1, "mrst_burst");
    cyc(1, 4'b0000, 0, 4'b0000, 0, "mrst_end");

`ifdef FIFO_WR_ARB_STATS_EN
    // Twenty accepts from requester 0 saturate a 4-bit counter.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cyc(1, 4'b0001, 0, 4'b0000, 0, "sat_bubble");
      for (int b = 0; b < 4; b++) cyc(1, 4'b0001, 0, 4'b0001, 1, "sat_beat");
    end
    cyc(1, 4'b0000, 0, 4'b0000, 0, "sat_end");
    chk("sat_word_cnt0", 32'(word_cnt[3:0]), 32'd15);
    chk("sat_word_cnt1", 32'(word_cnt[7:4]), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
